// File: rtl/alu_seq_pkg.sv
// Shared opcodes, status bit positions and FSM state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_NOT = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_ADD = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;
  localparam logic [3:0] OP_MOD = 4'd13;

  localparam int unsigned ST_INV  = 0;
  localparam int unsigned ST_ZERO = 1;
  localparam int unsigned ST_SIGN = 2;
  localparam int unsigned ST_CV   = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift-add multiply and (with ALU_SEQ_DIV_EN) restoring divide.
// One step per cycle for WIDTH cycles after start_i; done_o marks the final step.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
`ifdef ALU_SEQ_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // hi/lo hold partial product/multiplier for MUL, remainder/quotient for DIV.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
`endif

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, opd_q});
    if (div_q) begin
      // A kept remainder is always below the divisor, so WIDTH bits suffice.
      step_hi = ge ? WIDTH'(rem_sh - {1'b0, opd_q}) : rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    opd_d = opd_q;
`ifdef ALU_SEQ_DIV_EN
    div_d = div_q;
`endif
    if (start_i) begin
      cnt_d = CNT_W'(WIDTH);
      hi_d  = '0;
      lo_d  = b_i;
      opd_d = a_i;
`ifdef ALU_SEQ_DIV_EN
      div_d = div_i;
      if (div_i) begin
        lo_d  = a_i;
        opd_d = b_i;
      end
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      hi_d  = step_hi;
      lo_d  = step_lo;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opd_q <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opd_q <= opd_d;
`ifdef ALU_SEQ_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));
  assign lo_o   = step_lo;
  assign hi_o   = step_hi;

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with single-cycle ops and iterative MUL (DIV/MOD when
// ALU_SEQ_DIV_EN is defined). Result and status are held in DONE until out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       status
);

  localparam logic [WIDTH:0] One = (WIDTH+1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       st_q, st_d;
  logic [3:0]       op_q;
  logic             accept;
  logic             iter_op;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             res_cv, res_inv;
  logic [WIDTH-1:0] fin_y;
  logic             fin_cv;

  assign accept = in_valid && (state_q == IDLE);

  always_comb begin
    iter_op = (sel == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    // Divide by zero bypasses the iterator and completes in one cycle.
    if ((sel == OP_DIV || sel == OP_MOD) && b != '0) begin
      iter_op = 1'b1;
    end
`endif
  end

  alu_seq_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .start_i(accept && iter_op),
`ifdef ALU_SEQ_DIV_EN
    .div_i  (sel != OP_MUL),
`endif
    .a_i    (a),
    .b_i    (b),
    .done_o (iter_done),
    .lo_o   (iter_lo),
    .hi_o   (iter_hi)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = iter_op ? BUSY : DONE;
      BUSY:    if (iter_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Single-cycle results
  always_comb begin
    ext     = '0;
    res     = '0;
    res_cv  = 1'b0;
    res_inv = 1'b0;
    case (sel)
      OP_NOP: res = '0;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res    = {a[WIDTH-2:0], 1'b0};
        res_cv = a[WIDTH-1];
      end
      OP_SHR: begin
        res    = {1'b0, a[WIDTH-1:1]};
        res_cv = a[0];
      end
      OP_INC: begin
        ext    = {1'b0, a} + One;
        res    = ext[WIDTH-1:0];
        res_cv = ext[WIDTH];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - One;
        res    = ext[WIDTH-1:0];
        res_cv = ext[WIDTH];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        res    = ext[WIDTH-1:0];
        res_cv = ext[WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        res    = ext[WIDTH-1:0];
        res_cv = ext[WIDTH];
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        res    = '1;
        res_cv = 1'b1;
      end
      OP_MOD: begin
        res    = a;
        res_cv = 1'b1;
      end
`endif
      default: res_inv = 1'b1;
    endcase
  end

  // Final-step results from the iterator
  always_comb begin
    fin_y  = iter_lo;
    fin_cv = 1'b0;
    case (op_q)
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: fin_y = iter_lo;
      OP_MOD: fin_y = iter_hi;
`endif
      default: fin_cv = (iter_hi != '0);
    endcase
  end

  always_comb begin
    y_d  = y_q;
    st_d = st_q;
    if (accept && !iter_op) begin
      y_d           = res;
      st_d[ST_INV]  = res_inv;
      st_d[ST_ZERO] = (res == '0);
      st_d[ST_SIGN] = res[WIDTH-1];
      st_d[ST_CV]   = res_cv;
    end else if (state_q == BUSY && iter_done) begin
      y_d           = fin_y;
      st_d[ST_INV]  = 1'b0;
      st_d[ST_ZERO] = (fin_y == '0);
      st_d[ST_SIGN] = fin_y[WIDTH-1];
      st_d[ST_CV]   = fin_cv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q  <= '0;
      st_q <= '0;
      op_q <= '0;
    end else begin
      y_q  <= y_d;
      st_q <= st_d;
      if (accept) begin
        op_q <= sel;
      end
    end
  end

  assign y      = y_q;
  assign status = st_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16; DIV/MOD expectations follow
// whether ALU_SEQ_DIV_EN is defined.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   sel = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic [3:0]   status;

  int total = 0;
  int bad = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .status   (status)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present an op and hold it until the accepting edge; returns #1 after that edge.
  task automatic issue(input logic [3:0] s, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int guard = 0;
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles counted from the accept edge: 1 means out_valid is up right after it.
  task automatic wait_valid(output int n, output int busy_ready);
    n = 1;
    busy_ready = 0;
    while (!out_valid && n < 64) begin
      if (in_ready) busy_ready++;
      @(posedge clk); #1; n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (y !== 16'h0000 || status !== 4'b0000) begin
      bad++; $display("FAIL reset_out y=%h st=%b want y=0000 st=0000", y, status);
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hs out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_ops();
    logic [3:0]   t_sel [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                 4'd9, 4'd9, 4'd10, 4'd14, 4'd15};
    logic [W-1:0] t_a   [14] = '{16'h1234, 16'h00FF, 16'h8001, 16'h0003, 16'hFFFF, 16'h0000,
                                 16'hF0F0, 16'hF000, 16'hAAAA, 16'hFFFF, 16'h1234, 16'h0005,
                                 16'h1234, 16'h1234};
    logic [W-1:0] t_b   [14] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0FF0, 16'h000F, 16'hAAAA, 16'h0001, 16'h1111, 16'h0003,
                                 16'h0000, 16'h0000};
    logic [W-1:0] t_y   [14] = '{16'h0000, 16'hFF00, 16'h0002, 16'h0001, 16'h0000, 16'hFFFF,
                                 16'h00F0, 16'hF00F, 16'h0000, 16'h0000, 16'h2345, 16'h0002,
                                 16'h0000, 16'h0000};
    logic [3:0]   t_st  [14] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1010, 4'b1100,
                                 4'b0000, 4'b0100, 4'b0010, 4'b1010, 4'b0000, 4'b0000,
                                 4'b0011, 4'b0011};
    int n, br;
    for (int i = 0; i < 14; i++) begin
      issue(t_sel[i], t_a[i], t_b[i]);
      wait_valid(n, br);
      total++;
      if (n !== 1) begin
        bad++; $display("FAIL op%0d_latency got=%0d want=1", t_sel[i], n);
      end
      total++;
      if (y !== t_y[i] || status !== t_st[i]) begin
        bad++; $display("FAIL op%0d_result y=%h st=%b want y=%h st=%b",
                        t_sel[i], y, status, t_y[i], t_st[i]);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL op%0d_done_ready in_ready=%b want 0", t_sel[i], in_ready);
      end
      pop();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++; $display("FAIL op%0d_pop in_ready=%b out_valid=%b want 1/0",
                        t_sel[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] m_a  [3] = '{16'h0100, 16'hFFFF, 16'h0003};
    logic [W-1:0] m_b  [3] = '{16'h0100, 16'hFFFF, 16'h0005};
    logic [W-1:0] m_y  [3] = '{16'h0000, 16'h0001, 16'h000F};
    logic [3:0]   m_st [3] = '{4'b1010, 4'b1000, 4'b0000};
    int n, br;
    for (int i = 0; i < 3; i++) begin
      issue(4'd11, m_a[i], m_b[i]);
      wait_valid(n, br);
      total++;
      if (n !== 17 || br !== 0) begin
        bad++; $display("FAIL mul%0d_latency got=%0d ready_hits=%0d want 17/0", i, n, br);
      end
      total++;
      if (y !== m_y[i] || status !== m_st[i]) begin
        bad++; $display("FAIL mul%0d_result y=%h st=%b want y=%h st=%b",
                        i, y, status, m_y[i], m_st[i]);
      end
      pop();
    end
  endtask

  task automatic test_div();
`ifdef ALU_SEQ_DIV_EN
    logic [3:0]   d_sel [4] = '{4'd12, 4'd13, 4'd12, 4'd13};
    logic [W-1:0] d_a   [4] = '{16'd100, 16'd100, 16'd5, 16'd5};
    logic [W-1:0] d_b   [4] = '{16'd7, 16'd7, 16'd0, 16'd0};
    int           d_n   [4] = '{17, 17, 1, 1};
    logic [W-1:0] d_y   [4] = '{16'd14, 16'd2, 16'hFFFF, 16'd5};
    logic [3:0]   d_st  [4] = '{4'b0000, 4'b0000, 4'b1100, 4'b1000};
`else
    logic [3:0]   d_sel [4] = '{4'd12, 4'd13, 4'd12, 4'd13};
    logic [W-1:0] d_a   [4] = '{16'd100, 16'd100, 16'd5, 16'd5};
    logic [W-1:0] d_b   [4] = '{16'd7, 16'd7, 16'd0, 16'd0};
    int           d_n   [4] = '{1, 1, 1, 1};
    logic [W-1:0] d_y   [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
    logic [3:0]   d_st  [4] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011};
`endif
    int n, br;
    for (int i = 0; i < 4; i++) begin
      issue(d_sel[i], d_a[i], d_b[i]);
      wait_valid(n, br);
      total++;
      if (n !== d_n[i]) begin
        bad++; $display("FAIL div%0d_latency got=%0d want=%0d", i, n, d_n[i]);
      end
      total++;
      if (y !== d_y[i] || status !== d_st[i]) begin
        bad++; $display("FAIL div%0d_result y=%h st=%b want y=%h st=%b",
                        i, y, status, d_y[i], d_st[i]);
      end
      pop();
    end
  endtask

  task automatic test_backpressure();
    int n, br;
    issue(4'd10, 16'd3, 16'd5);
    wait_valid(n, br);
    total++;
    if (n !== 1) begin
      bad++; $display("FAIL bp_latency got=%0d want=1", n);
    end
    sel = 4'd9; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (y !== 16'hFFFE || status !== 4'b1100 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d y=%h st=%b ov=%b ir=%b want FFFE/1100/1/0",
                        i, y, status, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pop();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 16'hFFFE) begin
      bad++; $display("FAIL bp_release ir=%b ov=%b y=%h want 1/0/FFFE", in_ready, out_valid, y);
    end
  endtask

  task automatic test_reset_mid();
    int n, br;
    issue(4'd11, 16'h1234, 16'h0003);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (y !== 16'h0000 || status !== 4'b0000 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async y=%h st=%b ov=%b want 0000/0000/0", y, status, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
    issue(4'd9, 16'd2, 16'd3);
    wait_valid(n, br);
    total++;
    if (n !== 1 || y !== 16'd5 || status !== 4'b0000) begin
      bad++; $display("FAIL rst_mid_add lat=%0d y=%h st=%b want 1/0005/0000", n, y, status);
    end
    pop();
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
